// File: rtl/cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// cmp_res_t is the one-hot gt/eq/lt cascade passed from digit to digit.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_INIT = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
  localparam cmp_res_t CMP_RES_GT   = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
  localparam cmp_res_t CMP_RES_LT   = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit comparator slice: a ripple of per-bit cells, low bit
// first, where any differing bit overrides everything below it.
module cmp_digit
  import cmp_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic     [DIGIT-1:0] a,
  input  logic     [DIGIT-1:0] b,
  input  cmp_res_t             res_in,
  output cmp_res_t             res_out
);

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    cmp_res_t r_prev;
    cmp_res_t r;

    if (i == 0) begin : g_first
      assign r_prev = res_in;
    end else begin : g_next
      assign r_prev = g_bit[i-1].r;
    end

    assign r = (a[i] & ~b[i]) ? CMP_RES_GT :
               (~a[i] & b[i]) ? CMP_RES_LT : r_prev;
  end

  assign res_out = g_bit[DIGIT-1].r;

endmodule

// File: rtl/seq_cmp.sv
// Multi-cycle magnitude comparator: DIGIT bits per clock, LSB digit first,
// signed or unsigned, valid/ready on both sides, kill aborts in-flight work.
module seq_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_cmp: need WIDTH >= 2 and DIGIT dividing WIDTH");
  end

  cmp_state_t       state;
  cmp_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  cmp_res_t         casc;
  cmp_res_t         digit_res;
  cmp_res_t         res;
  logic             accept;
  logic             last_step;

  assign accept    = in_valid && in_ready && !kill;
  assign last_step = (cnt == CNT_W'(N - 1));

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a       (sh_a[DIGIT-1:0]),
    .b       (sh_b[DIGIT-1:0]),
    .res_in  (casc),
    .res_out (digit_res)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // kill outranks both the new accept and the output handshake.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (kill)           state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (kill)           state_nxt = IDLE;
        else if (accept)    state_nxt = RUN;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: in_ready = !rst;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Flipping the MSB maps two's-complement order onto unsigned order, so the
  // digit cells never need to know the mode.
  // NOTE: the shift registers are plain flops, so resetting them is cheap and
  // keeps the datapath free of X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sh_a <= '0;
      sh_b <= '0;
      casc <= CMP_RES_INIT;
      res  <= '0;
    end else if (accept) begin
      cnt  <= '0;
      sh_a <= a ^ {sgn, {(WIDTH-1){1'b0}}};
      sh_b <= b ^ {sgn, {(WIDTH-1){1'b0}}};
      casc <= CMP_RES_INIT;
    end else if (state == RUN && !kill) begin
      cnt  <= cnt + CNT_W'(1);
      sh_a <= sh_a >> DIGIT;
      sh_b <= sh_b >> DIGIT;
      casc <= digit_res;
      if (last_step) res <= digit_res;
    end
  end

  assign gt = res.gt;
  assign eq = res.eq;
  assign lt = res.lt;

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot({gt, eq, lt}));

  a_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !kill) |=> out_valid);

endmodule

// File: doc/seq_cmp.md
Name: seq_cmp

Overview:
Multi-cycle, parametrised magnitude comparator for the branch/SLT path. It compares two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, carrying a three-state cascade result (gt/eq/lt) between digits. It supports signed and unsigned modes and uses valid/ready handshakes on both the input and output sides. A kill input aborts an in-flight compare, for example on a pipeline flush.

Parameters:
WIDTH, 32, operand width in bits; must be at least 2.
DIGIT, 4, bits consumed per cycle; must divide WIDTH; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sgn  input  1  1 = two's-complement compare; 0 = unsigned
kill  input  1  abort current operation; drop any pending result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- N = WIDTH/DIGIT digit steps. States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, step counter=0, cascade={gt=0,eq=1,lt=0}, out_valid=0, gt=0, eq=0, lt=0. in_ready=1 once reset deasserts.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; never depends on in_valid.
- Accept = in_valid && in_ready && !kill. On an accept edge:
  - Load shift registers with a and b. If sgn=1, MSB of each operand is inverted on load (bias to offset-binary), which makes signed order equal unsigned order of the loaded values.
  - Cascade resets to {0,1,0}, counter=0, state=RUN.
- RUN, each cycle:
  - Consume the low DIGIT bits of both shift registers through the digit cell; shift both right by DIGIT.
  - Digit rule: bits examined low to high. At each bit, a>b forces {1,0,0}; a<b forces {0,0,1}; equal bits propagate the incoming cascade. The higher bit wins.
  - counter++. When counter reaches N-1 on this edge, the state becomes DONE and gt/eq/lt register the final cascade.
- Latency: out_valid rises exactly N cycles after the accept edge. Example: WIDTH=32, DIGIT=4 gives 8 cycles; DIGIT=WIDTH gives 1 cycle.
- DONE: out_valid=1. gt/eq/lt are stable and exactly one-hot until the handshake completes.
  - out_ready=1 without a new accept: return to IDLE, out_valid=0 next cycle. gt/eq/lt hold their last values, but are don't-care while out_valid=0.
  - out_ready=1 with a new accept on the same edge: go directly to RUN with the new operands. This is back-to-back operation with no bubble state.
  - out_ready=0: hold indefinitely. in_ready=0.
- kill=1 (sampled on a clock edge) in RUN or DONE: state=IDLE, out_valid=0 next cycle, result discarded. kill in IDLE: no effect. kill has priority over both accept and out handshake on the same edge.
- a, b and sgn are sampled only on the accept edge; later changes are ignored.
- Boundaries:
  - Signed 0x80000000 vs 0x7FFFFFFF gives lt.
  - Unsigned 0x80000000 vs 0x7FFFFFFF gives gt.
  - 0xFFFFFFFF vs 0x00000000 gives lt when signed and gt when unsigned.
  - Equal operands give eq in both modes.
- Assertions: gt+eq+lt==1 whenever out_valid; out_valid never drops without out_ready or kill; DIGIT divides WIDTH (elaboration check).

Decomposition:
- Package cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
  - packed struct cmp_res_t {gt, eq, lt};
  - constant CMP_RES_INIT = {0,1,0}.
- One sub-module, cmp_digit (parameter DIGIT): combinational. Inputs are DIGIT bits of a, DIGIT bits of b, and the incoming cmp_res_t; output is the outgoing cmp_res_t. It is the generate-loop cascade of per-bit cells.
- seq_cmp owns the FSM, counter ($clog2(N)+1 bits), shift registers and result register.

Test Plan:
- WIDTH=32, DIGIT=4, sgn=1, a=0x80000000, b=0x7FFFFFFF, out_ready=1 -> out_valid rises 8 cycles after accept; lt=1, gt=0, eq=0. Same operands with sgn=0 -> gt=1.
- sgn=1, a=b=0xDEADBEEF -> eq=1; then a=0x00000001, b=0x00000000 -> gt=1. Both use the same latency, and in_ready=0 throughout RUN.
- Back-to-back, in_valid held with out_ready=1: first pair a=5, b=9 gives lt; second pair a=-3, b=-7 (signed) gives gt. The second out_valid is exactly 8 cycles after the first DONE edge, with no idle cycle.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and the result hold steady, and in_ready=0. Then out_ready=1 -> IDLE next cycle.
- kill asserted on the 3rd RUN cycle -> IDLE next cycle, and no out_valid ever appears for that request. A new request is accepted the following cycle with full latency.
- Async rst pulsed mid-RUN between clock edges -> outputs clear immediately. Re-parameterise with WIDTH=8, DIGIT=8 and DIGIT=1: with sgn=1, a=0x80 vs b=0x01 gives lt, at 1-cycle and 8-cycle latency respectively. Random signed/unsigned cross-check against a golden model for 10k pairs, about 40% equal.
